// File: rtl/if_icache_line.sv
// Instruction-fetch stage with a direct-mapped, multi-word-line instruction cache.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module if_icache_line #(
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  output logic        if_stall_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_done_i,
  output logic        dbg_state_o
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int IDX_W   = $clog2(SETS);
  localparam int WOFF_W  = $clog2(LINE_WORDS);
  localparam int OFF_W   = (WOFF_W > 0) ? WOFF_W : 1;
  localparam int LINE_SH = 2 + WOFF_W;
  localparam int TAG_SH  = LINE_SH + IDX_W;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e             state_q;
  logic               mem_req_q;
  logic [31:0]        base_q;
  logic [OFF_W-1:0]   ptr_q;
  logic [OFF_W-1:0]   cnt_q;
  logic               cancel_q;
  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [31:0]        data_q [SETS][LINE_WORDS];

  logic [IDX_W-1:0]   idx;
  logic [OFF_W-1:0]   woff;
  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   ref_idx;
  logic [TAG_W-1:0]   ref_tag;
  logic [OFF_W-1:0]   ptr_nxt;
  logic               hit;
  logic               refill_done;
  logic               last_word;
  logic               fwd;
  logic               miss_start;

  assign idx     = IDX_W'(pc_i >> LINE_SH);
  assign woff    = OFF_W'((pc_i >> 2) & 32'(LINE_WORDS - 1));
  assign tag     = TAG_W'(pc_i >> TAG_SH);
  assign ref_idx = IDX_W'(base_q >> LINE_SH);
  assign ref_tag = TAG_W'(base_q >> TAG_SH);
  // Pointer wraps inside the line so the critical word is fetched first.
  assign ptr_nxt = OFF_W'((32'(ptr_q) + 32'd1) & 32'(LINE_WORDS - 1));

  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = base_q | (32'(ptr_q) << 2);
  assign dbg_state_o = (state_q == REFILL);

  assign hit         = valid_q[idx] && (tag_q[idx] == tag);
  assign refill_done = (state_q == REFILL) && mem_done_i;
  assign last_word   = (32'(cnt_q) == 32'(LINE_WORDS - 1));
  assign fwd         = refill_done && pc_valid_i && (mem_addr_o == pc_i);
  assign miss_start  = (state_q == IDLE) && pc_valid_i && !hit && !flush_i;

  always_comb begin
    inst_valid_o = 1'b0;
    inst_o       = '0;
    pc_o         = '0;
    if (pc_valid_i && hit) begin
      inst_valid_o = 1'b1;
      inst_o       = data_q[idx][woff];
      pc_o         = pc_i;
    end else if (fwd) begin
      inst_valid_o = 1'b1;
      inst_o       = mem_data_i;
      pc_o         = pc_i;
    end
  end

  assign if_stall_o = pc_valid_i && !inst_valid_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      base_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      cancel_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            state_q   <= REFILL;
            mem_req_q <= 1'b1;
            base_q    <= pc_i & ~32'(LINE_WORDS * 4 - 1);
            ptr_q     <= woff;
            cnt_q     <= '0;
            cancel_q  <= 1'b0;
          end
        end
        REFILL: begin
          if (flush_i) cancel_q <= 1'b1;
          if (mem_done_i) begin
            ptr_q <= ptr_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (last_word) begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The set being replaced is invalidated up front so stale words never hit mid-refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      if (miss_start) valid_q[idx] <= 1'b0;
      if (refill_done && last_word && !cancel_q) valid_q[ref_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (refill_done) begin
      data_q[ref_idx][ptr_q] <= mem_data_i;
      if (last_word) tag_q[ref_idx] <= ref_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (pc_valid_i && hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_if_icache_line.sv
// Bench for if_icache_line: acts as mem_ctrl and compares every cycle with a set/tag model.
module tb_if_icache_line;

  localparam int SETS  = 128;
  localparam int LW    = 4;
  localparam int TAG_W = 9;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic        if_stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        mem_done_i;
  logic        dbg_state_o;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  if_icache_line #(.SETS(SETS), .LINE_WORDS(LW), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .flush_i(flush_i),
    .inst_o(inst_o), .pc_o(pc_o), .inst_valid_o(inst_valid_o), .if_stall_o(if_stall_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .mem_done_i(mem_done_i), .dbg_state_o(dbg_state_o)
`ifdef ICACHE_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // model state
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mvalid [SETS];
  int          mtag   [SETS];
  bit          refilling;
  bit          cancelled;
  logic [31:0] rbase;
  int          roff;
  int          rk;
  int          lat_cnt;
  int          lat_max;
  bit          last_valid;
  bit          last_done;
  logic [31:0] last_fwd_pc;
  int          s_hits;
  int          s_miss;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 32'(4 * LW)) % 32'(SETS));
  endfunction

  function automatic int m_tag(input logic [31:0] a);
    return int'((a / 32'(4 * LW * SETS)) % 32'(1 << TAG_W));
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return mvalid[m_idx(a)] && (mtag[m_idx(a)] == m_tag(a));
  endfunction

  function automatic int next_lat();
    return (lat_max == 0) ? int'($urandom_range(0, 2)) : lat_max - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
    refilling = 1'b0;
    cancelled = 1'b0;
    rk        = 0;
    s_hits    = 0;
    s_miss    = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one clock cycle, entered and left 1 time unit after a rising edge
  task automatic cycle();
    logic [31:0] eaddr;
    logic [31:0] pc_s;
    bit          ehit;
    bit          efwd;
    bit          evalid;
    bit          pv;
    bit          fl;
    bit          dn;
    int          i;
    eaddr = rbase + 32'(((roff + rk) % LW) * 4);
    if (refilling && lat_cnt == 0) begin
      mem_done_i = 1'b1;
      mem_data_i = mem_word(eaddr);
    end else begin
      mem_done_i = 1'b0;
      mem_data_i = $urandom;
    end
    @(negedge clk);
    pc_s   = pc_i;
    pv     = pc_valid_i;
    fl     = flush_i;
    dn     = mem_done_i;
    ehit   = m_hit(pc_s);
    efwd   = refilling && dn && (eaddr == pc_s);
    evalid = pv && (ehit || efwd);
    chk("inst_valid", 32'(inst_valid_o), 32'(evalid));
    chk("inst", inst_o, evalid ? mem_word(pc_s) : 32'h0);
    chk("pc_out", pc_o, evalid ? pc_s : 32'h0);
    chk("stall", 32'(if_stall_o), 32'(pv && !evalid));
    chk("mem_req", 32'(mem_req_o), 32'(refilling));
    chk("state", 32'(dbg_state_o), 32'(refilling));
    if (refilling) chk("mem_addr", mem_addr_o, eaddr);
    if (dn && exp_q.size() > 0) chk("addr_seq", mem_addr_o, exp_q.pop_front());
    if (efwd) last_fwd_pc = pc_s;
    if (pv && ehit) s_hits++;
    last_valid = evalid;
    last_done  = dn;
    @(posedge clk);
    i = m_idx(pc_s);
    if (refilling) begin
      if (fl) cancelled = 1'b1;
      if (dn) begin
        rk++;
        lat_cnt = next_lat();
        if (rk == LW) begin
          refilling = 1'b0;
          if (!cancelled) begin
            mvalid[m_idx(rbase)] = 1'b1;
            mtag[m_idx(rbase)]   = m_tag(rbase);
          end
        end
      end else begin
        lat_cnt--;
      end
    end else if (pv && !ehit && !fl) begin
      mvalid[i] = 1'b0;
      refilling = 1'b1;
      cancelled = 1'b0;
      rbase     = pc_s - (pc_s % 32'(4 * LW));
      roff      = int'((pc_s / 4) % LW);
      rk        = 0;
      lat_cnt   = next_lat();
      s_miss++;
    end
    if (fl) for (int j = 0; j < SETS; j++) mvalid[j] = 1'b0;
    #1;
  endtask

  task automatic fetch_until(input logic [31:0] a, input int maxc, input string tag);
    pc_i       = a;
    pc_valid_i = 1'b1;
    for (int c = 0; c < maxc; c++) begin
      cycle();
      if (last_valid) return;
    end
    n_tests++;
    n_fail++;
    $error("FAIL %s: observed timeout expected instruction within %0d cycles", tag, maxc);
  endtask

  task automatic wait_refill(input int maxc, input string tag);
    for (int c = 0; c < maxc; c++) begin
      if (!refilling) return;
      cycle();
    end
    n_tests++;
    n_fail++;
    $error("FAIL %s: observed refill still active expected done within %0d cycles", tag, maxc);
  endtask

  task automatic run_until_words(input int words, input int maxc, input string tag);
    for (int c = 0; c < maxc; c++) begin
      if (rk >= words || !refilling) return;
      cycle();
    end
    n_tests++;
    n_fail++;
    $error("FAIL %s: observed %0d words expected %0d", tag, rk, words);
  endtask

  initial begin
    rst_n = 1'b0; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0;
    mem_done_i = 1'b0; mem_data_i = '0;
    rbase = '0; roff = 0; lat_cnt = 0; lat_max = 2; last_fwd_pc = '0;
    model_reset();

    // reset values
    #2;
    chk("rst_inst_valid", 32'(inst_valid_o), 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_stall", 32'(if_stall_o), 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    // cold miss, critical word first, forwarded on its done cycle
    exp_q.push_back(32'h08); exp_q.push_back(32'h0C);
    exp_q.push_back(32'h00); exp_q.push_back(32'h04);
    fetch_until(32'h08, 20, "cold_fwd");
    chk("cold_fwd_on_done", 32'(last_done), 32'h1);
    pc_valid_i = 1'b0;
    wait_refill(50, "cold_refill");
    chk("cold_seq_len", 32'(exp_q.size()), 32'h0);
    for (int a = 0; a < 16; a += 4) begin
      pc_i = 32'(a); pc_valid_i = 1'b1;
      cycle();
      chk("warm_hit", 32'(last_valid), 32'h1);
    end

    // conflict in set 0
    fetch_until(32'h800, 30, "conflict_fill");
    pc_valid_i = 1'b0;
    wait_refill(50, "conflict_refill");
    pc_i = 32'h000; pc_valid_i = 1'b1;
    cycle();
    chk("conflict_remiss", 32'(last_valid), 32'h0);
    wait_refill(50, "conflict_refill2");

    // redirect after the first word
    pc_i = 32'h40; pc_valid_i = 1'b1;
    cycle();
    run_until_words(1, 30, "redirect_first");
    pc_i = 32'h44;
    last_fwd_pc = '0;
    wait_refill(50, "redirect_refill");
    chk("redirect_fwd", last_fwd_pc, 32'h44);
    pc_i = 32'h48;
    cycle();
    chk("redirect_hit", 32'(last_valid), 32'h1);

    // flush during refill cancels the line and drops older lines
    pc_i = 32'h100; pc_valid_i = 1'b1;
    cycle();
    cycle();
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0; pc_valid_i = 1'b0;
    wait_refill(50, "flush_refill");
    pc_i = 32'h100; pc_valid_i = 1'b1;
    cycle();
    chk("flush_cancel", 32'(last_valid), 32'h0);
    wait_refill(50, "flush_refill2");
    pc_i = 32'h000;
    cycle();
    chk("flush_clear", 32'(last_valid), 32'h0);
    wait_refill(50, "flush_refill3");

    // asynchronous reset between the 2nd and 3rd word
    pc_valid_i = 1'b0; flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    pc_i = 32'h08; pc_valid_i = 1'b1;
    cycle();
    run_until_words(2, 30, "reset_two_words");
    pc_valid_i = 1'b0;
    mem_done_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_req", 32'(mem_req_o), 32'h0);
    chk("reset_mid_state", 32'(dbg_state_o), 32'h0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    pc_i = 32'h08; pc_valid_i = 1'b1;
    cycle();
    chk("post_reset_miss", 32'(last_valid), 32'h0);
    wait_refill(50, "post_reset_refill");
    for (int k = 0; k < 3; k++) begin
      pc_i = 32'(k * 4);
      cycle();
      chk("post_reset_hit", 32'(last_valid), 32'h1);
    end

    // randomized traffic over a few sets and tags
    lat_max = 0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0)
        pc_i = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 4) |
               (32'($urandom_range(0, 3)) << 2);
      pc_valid_i = ($urandom_range(0, 3) != 0);
      flush_i    = ($urandom_range(0, 49) == 0);
      cycle();
    end
    flush_i = 1'b0; pc_valid_i = 1'b0;
    wait_refill(50, "random_drain");

`ifdef ICACHE_STATS_EN
    chk("hit_cnt", hit_cnt_o, 32'(s_hits));
    chk("miss_cnt", miss_cnt_o, 32'(s_miss));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
